// File: rtl/fetch_unit.sv
// Purpose: RV32I fetch stage. Owns the PC, issues word reads over req/ack and queues {pc, word} pairs for decode.
// Latency: mem_ack in cycle N gives instr_valid in cycle N+1. With ack and ready both held high it delivers one word per cycle.
// Backpressure: mem_req drops while the buffer is full. It returns the cycle after a pop frees an entry.
//
// Ports:
//   clk, nRst                    clock and asynchronous active-low reset
//   mem_req/mem_addr             word read request; held stable until mem_ack
//   mem_ack/mem_rdata            read completion; data valid with ack
//   redirect/redirect_pc         taken branch/jump target from execute; flushes everything in flight
//   instr/instr_pc/instr_valid   buffer head toward decode, accepted by instr_ready
//   misaligned                   sticky misaligned-redirect flag
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   When defined, a misaligned redirect sets misaligned and parks the unit in HALT until reset.
//   When undefined, the low two bits of redirect_pc are ignored.
// RESET_PC must be word-aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nRst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned
);

    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int unsigned      PTR_W   = $clog2(BUF_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    state_t           state_q, state_d;
    logic             run_q, run_d;             // holds mem_req low for the first cycle out of reset
    word_t            fetch_pc_q, fetch_pc_d;
    word_t            hold_addr_q, hold_addr_d; // address of the request being drained in FLUSH
    logic             halt_pend_q, halt_pend_d; // enter HALT once the drained request acks
    logic             misaligned_q, misaligned_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    word_t            buf_instr_q [BUF_DEPTH];
    word_t            buf_instr_d [BUF_DEPTH];
    word_t            buf_pc_q    [BUF_DEPTH];
    word_t            buf_pc_d    [BUF_DEPTH];

    logic  redir_bad;
    word_t redir_target;
    logic  push;
    logic  pop;
    logic  clear;

    assign instr_valid = (state_q == FETCH) && (count_q != '0);
    assign instr       = buf_instr_q[rd_ptr_q];
    assign instr_pc    = buf_pc_q[rd_ptr_q];
    assign misaligned  = misaligned_q;

    always_comb begin
        state_d      = state_q;
        run_d        = 1'b1;
        fetch_pc_d   = fetch_pc_q;
        hold_addr_d  = hold_addr_q;
        halt_pend_d  = halt_pend_q;
        misaligned_d = misaligned_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        mem_req      = 1'b0;
        mem_addr     = fetch_pc_q;
        push         = 1'b0;
        pop          = 1'b0;
        clear        = 1'b0;
        redir_target = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
        redir_bad    = redirect && (redirect_pc[1:0] != 2'b00);
`else
        redir_bad    = 1'b0;
`endif

        case (state_q)
            FETCH: begin
                // count only grows on ack, so this stays high for as long as a request is outstanding.
                mem_req = run_q && (count_q < DEPTH_C);
                if (redirect) begin
                    clear      = 1'b1;
                    fetch_pc_d = redir_target;
                    if (mem_req && !mem_ack) begin
                        // The in-flight read cannot be withdrawn. Keep presenting it and drop its data.
                        hold_addr_d = fetch_pc_q;
                        halt_pend_d = redir_bad;
                        state_d     = FLUSH;
                    end else if (redir_bad) begin
                        state_d = HALT;
                    end
                end else begin
                    push = mem_req && mem_ack;
                    pop  = instr_valid && instr_ready;
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
            end
            FLUSH: begin
                mem_req  = 1'b1;
                mem_addr = hold_addr_q;
                if (redirect) begin
                    fetch_pc_d = redir_target;
                end
                if (redir_bad) begin
                    halt_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d     = (halt_pend_q || redir_bad) ? HALT : FETCH;
                    halt_pend_d = 1'b0;
                end
            end
            HALT: begin
                clear = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        misaligned_d = misaligned_q | redir_bad;

        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = mem_rdata;
                buf_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= FETCH;
            run_q        <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            hold_addr_q  <= RESET_PC;
            halt_pend_q  <= 1'b0;
            misaligned_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_addr_q  <= hold_addr_d;
            halt_pend_q  <= halt_pend_d;
            misaligned_q <= misaligned_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (RESET_PC = 0, BUF_DEPTH = 2).
// The first part is a series of directed scenarios with cycle-exact expectations.
// The second part is a randomized run. The model for that run is an expected-PC stream:
//   - start at reset PC;
//   - advance by 4 on each accepted instruction;
//   - restart at the target on each redirect.
// The run also checks the hold rule with its own memory tracker.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk  = 1'b0;
    logic        nRst = 1'b1;
    logic        mem_req, mem_ack, redirect, instr_valid, instr_ready, misaligned;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .nRst(nRst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check1({pfx, "_mem_req"}, mem_req, 1'b0);
        check({pfx, "_mem_addr"}, mem_addr, 32'h0);
        check({pfx, "_instr"}, instr, 32'h0);
        check({pfx, "_instr_pc"}, instr_pc, 32'h0);
        check1({pfx, "_instr_valid"}, instr_valid, 1'b0);
        check1({pfx, "_misaligned"}, misaligned, 1'b0);
    endtask

    task automatic do_reset();
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        nRst        = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        nRst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pops;
        logic        pend;
        logic [31:0] pend_addr;
        logic [31:0] exp_pc;
        logic [31:0] tgt;

        // Zero-wait fetch: data = address, one instruction per cycle.
        do_reset();
        step();
        check1("t1_req_first", mem_req, 1'b1);
        check("t1_addr_first", mem_addr, 32'h0);
        check1("t1_vld_first", instr_valid, 1'b0);
        instr_ready = 1'b1;
        mem_ack     = mem_req;
        mem_rdata   = mem_addr;
        for (int i = 0; i < 4; i++) begin
            step();
            check1("t1_vld", instr_valid, 1'b1);
            check("t1_pc", instr_pc, 32'(4 * i));
            check("t1_instr", instr, 32'(4 * i));
            mem_ack   = mem_req;
            mem_rdata = mem_addr;
        end

        // Backpressure: two acks fill the buffer and the request stops.
        do_reset();
        step();
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        check1("t2_vld", instr_valid, 1'b1);
        check("t2_addr4", mem_addr, 32'h4);
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check1("t2_req_off", mem_req, 1'b0);
            check("t2_pc_hold", instr_pc, 32'h0);
            check1("t2_vld_hold", instr_valid, 1'b1);
            step();
        end
        check("t2_drain0", instr_pc, 32'h0);
        instr_ready = 1'b1;
        step();
        check("t2_drain4", instr_pc, 32'h4);
        check1("t2_req_back", mem_req, 1'b1);
        check("t2_next_addr", mem_addr, 32'h8);
        instr_ready = 1'b0;

        // Redirect while the request to 0x8 is still waiting for its ack.
        do_reset();
        step();
        instr_ready = 1'b1;
        mem_ack     = 1'b1;
        mem_rdata   = mem_addr;
        step();
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        check("t3_addr8", mem_addr, 32'h8);
        mem_ack = 1'b0;
        step();
        check1("t3_empty", instr_valid, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check1("t3_req_held", mem_req, 1'b1);
        check("t3_hold1", mem_addr, 32'h8);
        step();
        check("t3_hold2", mem_addr, 32'h8);
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        check1("t3_dropped", instr_valid, 1'b0);
        check("t3_new_addr", mem_addr, 32'h100);
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        check1("t3_vld", instr_valid, 1'b1);
        check("t3_pc", instr_pc, 32'h100);
        check("t3_instr", instr, 32'h100);

        // Redirect in the same cycle as an ack.
        mem_ack     = 1'b1;
        mem_rdata   = mem_addr;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check1("t4_vld_drop", instr_valid, 1'b0);
        check("t4_addr", mem_addr, 32'h200);
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        check1("t4_vld", instr_valid, 1'b1);
        check("t4_pc", instr_pc, 32'h200);

        // Misaligned redirect to 0x102.
        mem_ack     = 1'b1;
        mem_rdata   = mem_addr;
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("t5_misaligned", misaligned, 1'b1);
            check1("t5_req_off", mem_req, 1'b0);
            check1("t5_vld_off", instr_valid, 1'b0);
            step();
        end
`else
        check1("t5_misaligned", misaligned, 1'b0);
        check("t5_addr", mem_addr, 32'h100);
        check1("t5_vld_drop", instr_valid, 1'b0);
        mem_ack   = mem_req;
        mem_rdata = mem_addr;
        step();
        check1("t5_vld", instr_valid, 1'b1);
        check("t5_pc", instr_pc, 32'h100);
        check1("t5_misaligned_late", misaligned, 1'b0);
        mem_ack = 1'b0;
`endif

        // Asynchronous reset mid-stream: one entry buffered and a request outstanding.
        do_reset();
        step();
        mem_ack   = 1'b1;
        mem_rdata = mem_addr;
        step();
        mem_ack = 1'b0;
        step();
        check1("t6_pre_vld", instr_valid, 1'b1);
        check1("t6_pre_req", mem_req, 1'b1);
        #2;
        mem_ack = 1'b0;
        nRst    = 1'b0;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        nRst = 1'b1;
        step();
        check1("t6_restart_req", mem_req, 1'b1);
        check("t6_restart_addr", mem_addr, 32'h0);

        // Randomized run against the expected-PC stream model.
        do_reset();
        exp_pc    = 32'h0;
        pend      = 1'b0;
        pend_addr = 32'h0;
        pops      = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (pend) begin
                check1("rnd_req_held", mem_req, 1'b1);
                check("rnd_addr_held", mem_addr, pend_addr);
            end
            if (mem_req) begin
                check("rnd_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
            end
            mem_ack     = mem_req && ($urandom_range(0, 3) != 0);
            mem_rdata   = mem_addr ^ KEY;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                              : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            redirect_pc = tgt;
            if (redirect) begin
                exp_pc = tgt;
            end else if (instr_valid && instr_ready) begin
                check("rnd_pc", instr_pc, exp_pc);
                check("rnd_instr", instr, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            pend      = mem_req && !mem_ack;
            pend_addr = mem_addr;
        end
        mem_ack     = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check1("rnd_liveness", pops > 300, 1'b1);
        check1("rnd_misaligned", misaligned, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
